// File: rtl/connect_board_engine_pkg.sv
// Shared definitions for the Connect-N board engine:
// result codes, command opcodes, FSM states and scan direction deltas.
package connect_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DROP,
        S_CHECK,
        S_CLEAR,
        S_REPORT
    } state_e;

    // Scan order: horizontal, vertical, diagonal, anti-diagonal
    typedef enum logic [1:0] {
        DIR_H,
        DIR_V,
        DIR_D,
        DIR_A
    } dir_e;

    localparam logic [2:0] RESULT_OK      = 3'd0;
    localparam logic [2:0] RESULT_FULL    = 3'd1;
    localparam logic [2:0] RESULT_BAD     = 3'd2;
    localparam logic [2:0] RESULT_WIN     = 3'd3;
    localparam logic [2:0] RESULT_DRAW    = 3'd4;
    localparam logic [2:0] RESULT_CLEARED = 3'd5;

    localparam logic OP_DROP  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    function automatic logic signed [4:0] dir_dx(dir_e d);
        case (d)
            DIR_V:   return 5'sd0;
            default: return 5'sd1;
        endcase
    endfunction

    function automatic logic signed [4:0] dir_dy(dir_e d);
        case (d)
            DIR_H:   return 5'sd0;
            DIR_A:   return -5'sd1;
            default: return 5'sd1;
        endcase
    endfunction

endpackage

// File: rtl/connect_board_engine_if.sv
// Command/result handshake bundle between game FSM (master) and engine (slave).
// VALID/READY command channel plus DONE-qualified RESULT/WIN_PLAYER/PIECE_ROW.
interface connect_board_engine_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CMD_OP;
    logic [3:0] CMD_COL;
    logic [1:0] CMD_PLAYER;
    logic       DONE;
    logic [2:0] RESULT;
    logic [1:0] WIN_PLAYER;
    logic [3:0] PIECE_ROW;

    modport master (
        output CMD_VALID, CMD_OP, CMD_COL, CMD_PLAYER,
        input  CMD_READY, DONE, RESULT, WIN_PLAYER, PIECE_ROW
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_COL, CMD_PLAYER,
        output CMD_READY, DONE, RESULT, WIN_PLAYER, PIECE_ROW
    );
endinterface

// File: rtl/connect_board_engine_grid.sv
// board_ram_grid: COLS x ROWS array of 2-bit cells, one write port with a
// whole-column clear strobe, two async read ports (scan a, display b).
module board_ram_grid #(
    parameter int COLS = 7,
    parameter int ROWS = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic [3:0] wcol_i,
    input  logic [3:0] wrow_i,
    input  logic [1:0] wdata_i,
    input  logic       clr_i,
    input  logic [3:0] clr_col_i,
    input  logic [3:0] ra_col_i,
    input  logic [3:0] ra_row_i,
    output logic [1:0] ra_data_o,
    input  logic [3:0] rb_col_i,
    input  logic [3:0] rb_row_i,
    output logic [1:0] rb_data_o
);
    localparam int CB = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RB = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [3:0] C4 = 4'(COLS);
    localparam logic [3:0] R4 = 4'(ROWS);

    logic [1:0] cell_q [COLS][ROWS];

    logic ra_ok, rb_ok;
    assign ra_ok = (ra_col_i < C4) && (ra_row_i < R4);
    assign rb_ok = (rb_col_i < C4) && (rb_row_i < R4);

    assign ra_data_o = ra_ok ? cell_q[ra_col_i[CB-1:0]][ra_row_i[RB-1:0]] : 2'd0;
    assign rb_data_o = rb_ok ? cell_q[rb_col_i[CB-1:0]][rb_row_i[RB-1:0]] : 2'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < COLS; c++)
                for (int r = 0; r < ROWS; r++)
                    cell_q[c][r] <= 2'd0;
        end else begin
            if (we_i && wcol_i < C4 && wrow_i < R4)
                cell_q[wcol_i[CB-1:0]][wrow_i[RB-1:0]] <= wdata_i;
            if (clr_i && clr_col_i < C4)
                for (int r = 0; r < ROWS; r++)
                    cell_q[clr_col_i[CB-1:0]][r] <= 2'd0;
        end
    end
endmodule

// File: rtl/connect_board_engine.sv
// Connect-N board engine: drop/clear commands over cmd (slave), win/draw scan,
// RD_COL/RD_ROW -> RD_CELL display read port, BOARD_FULL level output.
module connect_board_engine
    import connect_pkg::*;
#(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    connect_board_engine_if.slave   cmd,
    input  logic [3:0]              RD_COL,
    input  logic [3:0]              RD_ROW,
    output logic [1:0]              RD_CELL,
    output logic                    BOARD_FULL
);
    localparam int CELLS = COLS * ROWS;
    localparam int CW    = $clog2(CELLS + 1);
    localparam int CB    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [3:0] COLS4 = 4'(COLS);
    localparam logic [3:0] ROWS4 = 4'(ROWS);
    localparam logic [3:0] LAST_STEP = 4'(WIN_LEN - 1);
    localparam logic [4:0] WIN5 = 5'(WIN_LEN);
    localparam logic signed [4:0] COLS_S = 5'(COLS);
    localparam logic signed [4:0] ROWS_S = 5'(ROWS);
    localparam logic [CW-1:0] FULL = CW'(CELLS);

    state_e            state_q;
    dir_e              dir_q;
    logic              neg_q;
    logic [3:0]        step_q;
    logic [4:0]        run_q;
    logic signed [4:0] sx_q, sy_q;
    logic [3:0]        col_q;
    logic [1:0]        player_q;
    logic [3:0]        height_q [COLS];
    logic [CW-1:0]     count_q;
    logic              ready_q, done_q;
    logic [2:0]        result_q;
    logic [1:0]        winp_q;
    logic [3:0]        prow_q;

    logic       col_ok, drop_ok, in_b, match, side_end;
    logic [3:0] height;
    logic [4:0] run_n;
    logic [1:0] scan_cell;
    dir_e       dir_n;
    logic signed [4:0] px, py;

    assign col_ok  = col_q < COLS4;
    assign height  = col_ok ? height_q[col_q[CB-1:0]] : 4'd0;
    assign drop_ok = col_ok && (player_q != 2'd0) && (height != ROWS4);

    assign in_b = (sx_q >= 5'sd0) && (sx_q < COLS_S) &&
                  (sy_q >= 5'sd0) && (sy_q < ROWS_S);
    assign match    = in_b && (scan_cell == player_q);
    assign run_n    = run_q + {4'd0, match};
    assign side_end = !match || (step_q == LAST_STEP);
    assign dir_n    = dir_e'(dir_q + 2'd1);
    assign px       = $signed({1'b0, col_q});
    assign py       = $signed({1'b0, prow_q});

    board_ram_grid #(.COLS(COLS), .ROWS(ROWS)) u_grid (
        .clk_i     (CLOCK_50),
        .rst_i     (RESET),
        .we_i      (state_q == S_DROP && drop_ok),
        .wcol_i    (col_q),
        .wrow_i    (height),
        .wdata_i   (player_q),
        .clr_i     (state_q == S_CLEAR),
        .clr_col_i (col_q),
        .ra_col_i  (sx_q[3:0]),
        .ra_row_i  (sy_q[3:0]),
        .ra_data_o (scan_cell),
        .rb_col_i  (RD_COL),
        .rb_row_i  (RD_ROW),
        .rb_data_o (RD_CELL)
    );

    assign cmd.CMD_READY  = ready_q;
    assign cmd.DONE       = done_q;
    assign cmd.RESULT     = result_q;
    assign cmd.WIN_PLAYER = winp_q;
    assign cmd.PIECE_ROW  = prow_q;
    assign BOARD_FULL     = (count_q == FULL);

    always_ff @(posedge CLOCK_50) begin
        done_q <= 1'b0;
        if (RESET) begin
            state_q  <= S_IDLE;
            dir_q    <= DIR_H;
            neg_q    <= 1'b0;
            step_q   <= 4'd0;
            run_q    <= 5'd0;
            sx_q     <= 5'sd0;
            sy_q     <= 5'sd0;
            col_q    <= 4'd0;
            player_q <= 2'd0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            result_q <= RESULT_OK;
            winp_q   <= 2'd0;
            prow_q   <= 4'd0;
            for (int c = 0; c < COLS; c++)
                height_q[c] <= 4'd0;
        end else begin
            unique case (state_q)
                S_IDLE: if (cmd.CMD_VALID) begin
                    ready_q  <= 1'b0;
                    player_q <= cmd.CMD_PLAYER;
                    if (cmd.CMD_OP == OP_CLEAR) begin
                        col_q   <= 4'd0;
                        state_q <= S_CLEAR;
                    end else begin
                        col_q   <= cmd.CMD_COL;
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (!col_ok || player_q == 2'd0 || height == ROWS4) begin
                        state_q  <= S_REPORT;
                        done_q   <= 1'b1;
                        result_q <= col_ok && player_q != 2'd0 ?
                                    RESULT_FULL : RESULT_BAD;
                        winp_q   <= 2'd0;
                    end else begin
                        height_q[col_q[CB-1:0]] <= height + 4'd1;
                        count_q <= count_q + CW'(1);
                        prow_q  <= height;
                        dir_q   <= DIR_H;
                        neg_q   <= 1'b0;
                        step_q  <= 4'd1;
                        run_q   <= 5'd1;
                        sx_q    <= $signed({1'b0, col_q}) + 5'sd1;
                        sy_q    <= $signed({1'b0, height});
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (run_n >= WIN5) begin
                        state_q  <= S_REPORT;
                        done_q   <= 1'b1;
                        result_q <= RESULT_WIN;
                        winp_q   <= player_q;
                    end else if (side_end) begin
                        step_q <= 4'd1;
                        if (!neg_q) begin
                            neg_q <= 1'b1;
                            run_q <= run_n;
                            sx_q  <= px - dir_dx(dir_q);
                            sy_q  <= py - dir_dy(dir_q);
                        end else if (dir_q == DIR_A) begin
                            state_q  <= S_REPORT;
                            done_q   <= 1'b1;
                            result_q <= (count_q == FULL) ? RESULT_DRAW : RESULT_OK;
                            winp_q   <= 2'd0;
                        end else begin
                            // Nothing sits above the new piece, so the
                            // vertical scan starts on its downward side.
                            dir_q <= dir_n;
                            run_q <= 5'd1;
                            neg_q <= (dir_n == DIR_V);
                            if (dir_n == DIR_V) begin
                                sx_q <= px;
                                sy_q <= py - 5'sd1;
                            end else begin
                                sx_q <= px + dir_dx(dir_n);
                                sy_q <= py + dir_dy(dir_n);
                            end
                        end
                    end else begin
                        step_q <= step_q + 4'd1;
                        run_q  <= run_n;
                        sx_q   <= neg_q ? sx_q - dir_dx(dir_q) : sx_q + dir_dx(dir_q);
                        sy_q   <= neg_q ? sy_q - dir_dy(dir_q) : sy_q + dir_dy(dir_q);
                    end
                end
                S_CLEAR: begin
                    height_q[col_q[CB-1:0]] <= 4'd0;
                    if (col_q == COLS4 - 4'd1) begin
                        count_q  <= '0;
                        state_q  <= S_REPORT;
                        done_q   <= 1'b1;
                        result_q <= RESULT_CLEARED;
                        winp_q   <= 2'd0;
                    end else begin
                        col_q <= col_q + 4'd1;
                    end
                end
                S_REPORT: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_connect_board_engine.sv
// Self-checking bench for connect_board_engine (7x6, connect 4):
// directed vector table, hand-written corner sequences, randomized model check.
module tb_connect_board_engine;
    localparam int C = 7;
    localparam int R = 6;
    localparam int W = 4;

    localparam int R_OK = 0, R_FULL = 1, R_BAD = 2, R_WIN = 3, R_DRAW = 4, R_CLR = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    connect_board_engine_if ifc();
    logic [3:0] rd_col = 4'd0;
    logic [3:0] rd_row = 4'd0;
    logic [1:0] rd_cell;
    logic       full;

    connect_board_engine #(.COLS(C), .ROWS(R), .WIN_LEN(W)) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .cmd        (ifc.slave),
        .RD_COL     (rd_col),
        .RD_ROW     (rd_row),
        .RD_CELL    (rd_cell),
        .BOARD_FULL (full)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural board model
    int mb[C][R];
    int mh[C];
    int mcount;
    int mrow;

    function automatic int line_len(int c, int r, int dx, int dy, int p);
        int n = 1;
        int x = c + dx;
        int y = r + dy;
        while (x >= 0 && x < C && y >= 0 && y < R && mb[x][y] == p) begin
            n++; x += dx; y += dy;
        end
        x = c - dx; y = r - dy;
        while (x >= 0 && x < C && y >= 0 && y < R && mb[x][y] == p) begin
            n++; x -= dx; y -= dy;
        end
        return n;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < C; c++) begin
            mh[c] = 0;
            for (int r = 0; r < R; r++) mb[c][r] = 0;
        end
        mcount = 0;
    endtask

    task automatic model(input int op, input int col, input int pl,
                         output int res, output int wp, output int row);
        int r;
        wp = 0;
        if (op == 1) begin
            model_clear();
            res = R_CLR;
        end else if (col >= C || pl == 0) begin
            res = R_BAD;
        end else if (mh[col] == R) begin
            res = R_FULL;
        end else begin
            r = mh[col];
            mb[col][r] = pl;
            mh[col]++;
            mcount++;
            mrow = r;
            if (line_len(col, r, 1, 0, pl) >= W || line_len(col, r, 0, 1, pl) >= W ||
                line_len(col, r, 1, 1, pl) >= W || line_len(col, r, 1, -1, pl) >= W) begin
                res = R_WIN;
                wp = pl;
            end else if (mcount == C * R) begin
                res = R_DRAW;
            end else begin
                res = R_OK;
            end
        end
        row = mrow;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        mrow = 0;
    endtask

    // Issue one command at a negedge; return at the negedge where DONE is seen.
    task automatic do_cmd(input int op, input int col, input int pl,
                          output int res, output int wp, output int row, output int lat);
        int n = 0;
        res = -1; wp = -1; row = -1; lat = -1;
        while (ifc.CMD_READY !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        ifc.CMD_VALID  = 1'b1;
        ifc.CMD_OP     = op[0];
        ifc.CMD_COL    = 4'(col);
        ifc.CMD_PLAYER = 2'(pl);
        @(negedge clk);
        ifc.CMD_VALID = 1'b0;
        n = 1;
        while (ifc.DONE !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) begin
            chk("done_timeout", 0, 1);
            return;
        end
        res = int'(ifc.RESULT);
        wp  = int'(ifc.WIN_PLAYER);
        row = int'(ifc.PIECE_ROW);
        lat = n;
    endtask

    task automatic model_step(input string tag, input int op, input int col, input int pl);
        int res, wp, row, lat, eres, ewp, erow;
        do_cmd(op, col, pl, res, wp, row, lat);
        model(op, col, pl, eres, ewp, erow);
        chk({tag, "_result"}, res, eres);
        chk({tag, "_winp"}, wp, ewp);
        chk({tag, "_row"}, row, erow);
        chk({tag, "_full"}, int'(full), int'(mcount == C * R));
    endtask

    function automatic int read_cell(int c, int r);
        rd_col = 4'(c);
        rd_row = 4'(r);
        return 0;
    endfunction

    task automatic chk_cell(input string nm, input int c, input int r, input int exp);
        rd_col = 4'(c);
        rd_row = 4'(r);
        #1;
        chk(nm, int'(rd_cell), exp);
    endtask

    typedef struct {
        int op;
        int col;
        int pl;
        int res;
        int wp;
        int row;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int op, input int col, input int pl,
                       input int res, input int wp, input int row);
        vec_t v;
        v.op = op; v.col = col; v.pl = pl; v.res = res; v.wp = wp; v.row = row;
        tbl.push_back(v);
    endtask

    initial begin
        int res, wp, row, lat, eres, ewp, erow, n, dones, p;

        ifc.CMD_VALID  = 1'b0;
        ifc.CMD_OP     = 1'b0;
        ifc.CMD_COL    = 4'd0;
        ifc.CMD_PLAYER = 2'd0;

        // Directed vectors: basic drop, bad commands, H/diag/anti wins, column full
        add(0, 3, 1, R_OK, 0, 0);   add(0, 9, 1, R_BAD, 0, 0);  add(0, 2, 0, R_BAD, 0, 0);
        add(0, 3, 2, R_OK, 0, 1);   add(0, 0, 1, R_OK, 0, 0);   add(0, 1, 1, R_OK, 0, 0);
        add(0, 2, 1, R_WIN, 1, 0);  add(1, 0, 0, R_CLR, 0, 0);
        add(0, 0, 1, R_OK, 0, 0);   add(0, 1, 2, R_OK, 0, 0);   add(0, 1, 1, R_OK, 0, 1);
        add(0, 2, 2, R_OK, 0, 0);   add(0, 2, 3, R_OK, 0, 1);   add(0, 2, 1, R_OK, 0, 2);
        add(0, 3, 2, R_OK, 0, 0);   add(0, 3, 3, R_OK, 0, 1);   add(0, 3, 3, R_OK, 0, 2);
        add(0, 3, 1, R_WIN, 1, 3);  add(1, 0, 0, R_CLR, 0, 3);
        add(0, 3, 1, R_OK, 0, 0);   add(0, 2, 2, R_OK, 0, 0);   add(0, 2, 1, R_OK, 0, 1);
        add(0, 1, 2, R_OK, 0, 0);   add(0, 1, 3, R_OK, 0, 1);   add(0, 1, 1, R_OK, 0, 2);
        add(0, 0, 2, R_OK, 0, 0);   add(0, 0, 3, R_OK, 0, 1);   add(0, 0, 2, R_OK, 0, 2);
        add(0, 0, 1, R_WIN, 1, 3);  add(1, 0, 0, R_CLR, 0, 3);
        add(0, 0, 1, R_OK, 0, 0);   add(0, 0, 1, R_OK, 0, 1);   add(0, 0, 1, R_OK, 0, 2);
        add(0, 0, 1, R_WIN, 1, 3);  add(0, 0, 1, R_WIN, 1, 4);  add(0, 0, 1, R_WIN, 1, 5);
        add(0, 0, 1, R_FULL, 0, 5);

        @(negedge clk);
        do_reset();

        chk("rst_ready", int'(ifc.CMD_READY), 1);
        chk("rst_done", int'(ifc.DONE), 0);
        chk("rst_result", int'(ifc.RESULT), 0);
        chk("rst_winp", int'(ifc.WIN_PLAYER), 0);
        chk("rst_row", int'(ifc.PIECE_ROW), 0);
        chk("rst_full", int'(full), 0);

        foreach (tbl[i]) begin
            do_cmd(tbl[i].op, tbl[i].col, tbl[i].pl, res, wp, row, lat);
            model(tbl[i].op, tbl[i].col, tbl[i].pl, eres, ewp, erow);
            chk($sformatf("vec%0d_result", i), res, tbl[i].res);
            chk($sformatf("vec%0d_winp", i), wp, tbl[i].wp);
            chk($sformatf("vec%0d_row", i), row, tbl[i].row);
            if (tbl[i].res == R_BAD || tbl[i].res == R_FULL)
                chk($sformatf("vec%0d_reject_latency", i), lat, 2);
            if (i == 0) chk_cell("first_drop_cell", 3, 0, 1);
            if (i == 2) chk_cell("bad_player_no_write", 2, 0, 0);
        end

        for (int r = 0; r < R; r++) chk_cell($sformatf("colfull_cell_r%0d", r), 0, r, 1);
        chk_cell("colfull_neighbor", 1, 0, 0);
        chk_cell("rd_out_of_range_col", 7, 0, 0);
        chk_cell("rd_out_of_range_row", 0, 6, 0);
        chk("colfull_not_board_full", int'(full), 0);

        // Fill the whole board with no 4-run, expect DRAW on the last drop
        model_step("pre_draw_clear", 1, 0, 0);
        for (int c = 0; c < C; c++)
            for (int r = 0; r < R; r++) begin
                p = ((c + r + (r >= 3 ? 1 : 0)) % 3) + 1;
                model_step($sformatf("fill_c%0d_r%0d", c, r), 0, c, p);
                res = int'(ifc.RESULT);
            end
        chk("draw_result", res, R_DRAW);
        chk("draw_board_full", int'(full), 1);
        model_step("drop_on_full_board", 0, 4, 2);

        do_cmd(1, 0, 0, res, wp, row, lat);
        model(1, 0, 0, eres, ewp, erow);
        chk("clear_result", res, R_CLR);
        chk("clear_latency", lat, C + 1);
        chk("clear_board_full", int'(full), 0);
        n = 0;
        for (int c = 0; c < C; c++)
            for (int r = 0; r < R; r++) begin
                rd_col = 4'(c); rd_row = 4'(r);
                #1;
                if (rd_cell != 2'd0) n++;
            end
        chk("clear_nonzero_cells", n, 0);

        // Reset asserted while the engine is scanning
        ifc.CMD_VALID = 1'b1; ifc.CMD_OP = 1'b0; ifc.CMD_COL = 4'd4; ifc.CMD_PLAYER = 2'd1;
        @(negedge clk);
        ifc.CMD_VALID = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        mrow = 0;
        chk("midrst_ready", int'(ifc.CMD_READY), 1);
        chk("midrst_result", int'(ifc.RESULT), 0);
        chk("midrst_row", int'(ifc.PIECE_ROW), 0);
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            if (ifc.DONE === 1'b1) dones++;
            @(negedge clk);
        end
        chk("midrst_no_done", dones, 0);
        chk_cell("midrst_cell_empty", 4, 0, 0);
        chk("midrst_full", int'(full), 0);

        // VALID held through a busy period: second command taken only once, in IDLE
        ifc.CMD_VALID = 1'b1; ifc.CMD_OP = 1'b0; ifc.CMD_COL = 4'd2; ifc.CMD_PLAYER = 2'd1;
        @(negedge clk);
        ifc.CMD_COL = 4'd5; ifc.CMD_PLAYER = 2'd2;
        n = 1;
        while (ifc.DONE !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("held_a_done_seen", int'(n < 100), 1);
        chk("held_a_result", int'(ifc.RESULT), R_OK);
        chk("held_a_row", int'(ifc.PIECE_ROW), 0);
        model(0, 2, 1, eres, ewp, erow);
        n = 0;
        while (ifc.CMD_READY !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        ifc.CMD_VALID = 1'b0;
        n = 1;
        while (ifc.DONE !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("held_b_done_seen", int'(n < 100), 1);
        chk("held_b_result", int'(ifc.RESULT), R_OK);
        model(0, 5, 2, eres, ewp, erow);
        chk_cell("held_a_cell", 2, 0, 1);
        chk_cell("held_b_cell", 5, 0, 2);
        chk_cell("held_b_single", 5, 1, 0);

        // Randomized play against the model
        model_step("rand_clear", 1, 0, 0);
        for (int k = 0; k < 400; k++) begin
            int op, col, pl;
            op  = ($urandom_range(0, 29) == 0) ? 1 : 0;
            col = $urandom_range(0, 8);
            pl  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            model_step($sformatf("rand%0d", k), op, col, pl);
            if (k % 8 == 0) begin
                int c, r;
                c = $urandom_range(0, C - 1);
                r = $urandom_range(0, R - 1);
                chk_cell($sformatf("rand%0d_cell", k), c, r, mb[c][r]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
